// File: rtl/dflow_pkg.sv
// Shared dflow types and constants: record widths, the 144-bit FIFO word layout and the length window.
// Used by tuple_packer and the downstream fifo_to_mem / mem_to_fifo / outqueue stages.
package dflow_pkg;

  localparam int PKT_TUPLE_WIDTH = 104;
  localparam int PKT_LEN_WIDTH   = 16;
  localparam int FIFO_DATA_WIDTH = 144;
  localparam int SEQ_WIDTH       = FIFO_DATA_WIDTH - 1 - PKT_LEN_WIDTH - PKT_TUPLE_WIDTH;
  localparam int FIFO_DEPTH_BITS = 5;
  localparam int NF_MARGIN       = 4;

  localparam logic [PKT_LEN_WIDTH-1:0] MIN_LEN = 16'd64;
  localparam logic [PKT_LEN_WIDTH-1:0] MAX_LEN = 16'd1518;

  typedef logic [PKT_TUPLE_WIDTH-1:0] tuple_t;
  typedef logic [PKT_LEN_WIDTH-1:0]   len_t;
  typedef logic [SEQ_WIDTH-1:0]       seq_t;

  // Field order fixes the word layout: [143] marker, [142:120] seq, [119:104] len, [103:0] tuple.
  typedef struct packed {
    logic   vld;
    seq_t   seq;
    len_t   len;
    tuple_t tuple;
  } fifo_word_t;

  function automatic logic len_ok(input len_t len);
    return (len >= MIN_LEN) && (len <= MAX_LEN);
  endfunction

endpackage

// File: rtl/tuple_packer_if.sv
// Record ingress handshake plus the FWFT drain port of the packer FIFO.
interface tuple_packer_if;
  import dflow_pkg::*;

  tuple_t                     fivetuple_data_in;
  len_t                       pkt_len_in;
  logic                       tuple_in_vld;
  logic                       tuple_in_ready;
  logic [FIFO_DATA_WIDTH-1:0] fifo_data_out;
  logic                       fifo_rd_en;
  logic                       fifo_empty;

  modport slave (
    input  fivetuple_data_in, pkt_len_in, tuple_in_vld, fifo_rd_en,
    output tuple_in_ready, fifo_data_out, fifo_empty
  );

  modport master (
    output fivetuple_data_in, pkt_len_in, tuple_in_vld, fifo_rd_en,
    input  tuple_in_ready, fifo_data_out, fifo_empty
  );

endinterface

// File: rtl/tuple_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is presented whenever the FIFO is non-empty.
module tuple_fifo #(
  parameter int WIDTH      = 144,
  parameter int DEPTH_BITS = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_BITS:0]   count
);

  localparam logic [DEPTH_BITS:0] DEPTH = (DEPTH_BITS+1)'(1 << DEPTH_BITS);

  logic [WIDTH-1:0]      mem_q [2**DEPTH_BITS];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH);
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & ~empty & ~clr;
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q + DEPTH_BITS'(do_push);
    rd_ptr_d = rd_ptr_q + DEPTH_BITS'(do_pop);
    count_d  = count_q + (DEPTH_BITS+1)'(do_push) - (DEPTH_BITS+1)'(do_pop);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; unwritten slots are never visible because rdata is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tuple_packer.sv
// Ingress stage: length-filters {5-tuple, len} records, stamps a sequence number and queues one
// 144-bit word per accepted record for fifo_to_mem.
module tuple_packer
  import dflow_pkg::*;
#(
  parameter int DEPTH_BITS = FIFO_DEPTH_BITS,
  parameter int MARGIN     = NF_MARGIN
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 sw_rst,
  input  logic                 store_en,
  tuple_packer_if.slave        bus,
  output logic [31:0]          stored_cnt,
  output logic [15:0]          drop_cnt,
  output logic                 overflow
);

  localparam logic [DEPTH_BITS:0] NF_LEVEL = (DEPTH_BITS+1)'((1 << DEPTH_BITS) - MARGIN);

  seq_t                       seq_q, seq_d;
  logic [31:0]                stored_cnt_q, stored_cnt_d;
  logic [15:0]                drop_cnt_q, drop_cnt_d;
  logic                       overflow_q, overflow_d;
  logic                       ready, xfer, accept, drop;
  logic                       fifo_full, fifo_empty;
  logic [DEPTH_BITS:0]        fifo_count;
  logic [FIFO_DATA_WIDTH-1:0] fifo_rdata;
  fifo_word_t                 wword;

  // Ready depends only on registered occupancy and store_en, never on vld or rd_en.
  assign ready = resetn & store_en & (fifo_count < NF_LEVEL);

  always_comb begin
    xfer   = bus.tuple_in_vld & ready & ~sw_rst;
    accept = xfer & len_ok(bus.pkt_len_in);
    drop   = xfer & ~len_ok(bus.pkt_len_in);
    wword  = '{vld: 1'b1, seq: seq_q, len: bus.pkt_len_in, tuple: bus.fivetuple_data_in};

    seq_d        = seq_q + SEQ_WIDTH'(accept);
    stored_cnt_d = stored_cnt_q + 32'(accept & ~fifo_full);
    drop_cnt_d   = drop_cnt_q;
    overflow_d   = overflow_q | (accept & fifo_full);
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;

    if (sw_rst) begin
      seq_d        = '0;
      stored_cnt_d = '0;
      drop_cnt_d   = '0;
      overflow_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seq_q        <= '0;
      stored_cnt_q <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      seq_q        <= seq_d;
      stored_cnt_q <= stored_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  tuple_fifo #(
    .WIDTH      (FIFO_DATA_WIDTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .clr    (sw_rst),
    .push   (accept),
    .pop    (bus.fifo_rd_en),
    .wdata  (wword),
    .rdata  (fifo_rdata),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_count)
  );

  assign bus.tuple_in_ready = ready;
  assign bus.fifo_data_out  = fifo_rdata;
  assign bus.fifo_empty     = fifo_empty;
  assign stored_cnt         = stored_cnt_q;
  assign drop_cnt           = drop_cnt_q;
  assign overflow           = overflow_q;

endmodule

// File: tb/tb_tuple_packer.sv
// Directed bench for tuple_packer: reset, ordering/latency, length filter, backpressure,
// sequence wrap, steady push+pop and both reset flavours.
module tb_tuple_packer;

  logic        clk = 1'b0;
  logic        resetn, sw_rst, store_en;
  logic [31:0] stored_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;
  int          total = 0;
  int          bad   = 0;

  tuple_packer_if bus ();

  tuple_packer dut (
    .clk        (clk),
    .resetn     (resetn),
    .sw_rst     (sw_rst),
    .store_en   (store_en),
    .bus        (bus),
    .stored_cnt (stored_cnt),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [143:0] mk_word(input logic [22:0] seq, input logic [15:0] len,
                                           input logic [103:0] tup);
    return {1'b1, seq, len, tup};
  endfunction

  function automatic logic [103:0] tup_of(input int n);
    return {8'hA5, 32'(n * 7 + 3), 32'hC0DE_0000 | 32'(n), 32'(~n)};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [15:0] len, input logic [103:0] tup);
    bus.tuple_in_vld      = vld;
    bus.pkt_len_in        = len;
    bus.fivetuple_data_in = tup;
  endtask

  task automatic apply_reset;
    resetn = 1'b0;
    sw_rst = 1'b0;
    store_en = 1'b1;
    bus.fifo_rd_en = 1'b0;
    drive(1'b0, 16'd0, '0);
    step;
    step;
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    sw_rst = 1'b0;
    store_en = 1'b1;
    bus.fifo_rd_en = 1'b0;
    drive(1'b1, 16'd100, tup_of(99));
    step;
    total++; if (bus.tuple_in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got=%b exp=0", bus.tuple_in_ready); end
    total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got=%b exp=1", bus.fifo_empty); end
    total++; if (bus.fifo_data_out !== 144'd0) begin bad++; $display("FAIL reset_data: got=%h exp=0", bus.fifo_data_out); end
    total++; if (stored_cnt !== 32'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL reset_counters: got stored=%0d drop=%0d ovf=%b exp 0/0/0", stored_cnt, drop_cnt, overflow);
    end
    drive(1'b0, 16'd0, '0);
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] lens [3];
    lens = '{16'd64, 16'd100, 16'd1518};
    apply_reset;
    bus.fifo_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, lens[i], tup_of(i));
      total++; if (bus.tuple_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got=%b exp=1", i, bus.tuple_in_ready); end
      step;
      total++; if (bus.fifo_empty !== 1'b0 || bus.fifo_data_out !== mk_word(23'(i), lens[i], tup_of(i))) begin
        bad++; $display("FAIL b2b_word%0d: got empty=%b data=%h exp empty=0 data=%h", i, bus.fifo_empty,
                        bus.fifo_data_out, mk_word(23'(i), lens[i], tup_of(i)));
      end
    end
    drive(1'b0, 16'd0, '0);
    step;
    total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("FAIL b2b_drained: got=%b exp=1", bus.fifo_empty); end
    total++; if (stored_cnt !== 32'd3) begin bad++; $display("FAIL b2b_stored: got=%0d exp=3", stored_cnt); end
    bus.fifo_rd_en = 1'b0;
  endtask

  task automatic test_len_filter;
    apply_reset;
    drive(1'b1, 16'd63, tup_of(10));
    step;
    total++; if (bus.fifo_empty !== 1'b1 || drop_cnt !== 16'd1) begin
      bad++; $display("FAIL len63: got empty=%b drop=%0d exp empty=1 drop=1", bus.fifo_empty, drop_cnt);
    end
    total++; if (bus.tuple_in_ready !== 1'b1) begin bad++; $display("FAIL len_ready: got=%b exp=1", bus.tuple_in_ready); end
    drive(1'b1, 16'd1519, tup_of(11));
    step;
    total++; if (bus.fifo_empty !== 1'b1 || drop_cnt !== 16'd2) begin
      bad++; $display("FAIL len1519: got empty=%b drop=%0d exp empty=1 drop=2", bus.fifo_empty, drop_cnt);
    end
    drive(1'b1, 16'd64, tup_of(12));
    step;
    drive(1'b0, 16'd0, '0);
    total++; if (bus.fifo_data_out !== mk_word(23'd0, 16'd64, tup_of(12)) || bus.fifo_empty !== 1'b0) begin
      bad++; $display("FAIL len64_word: got empty=%b data=%h exp data=%h", bus.fifo_empty, bus.fifo_data_out,
                      mk_word(23'd0, 16'd64, tup_of(12)));
    end
    total++; if (drop_cnt !== 16'd2 || stored_cnt !== 32'd1) begin
      bad++; $display("FAIL len_counts: got drop=%0d stored=%0d exp 2/1", drop_cnt, stored_cnt);
    end
  endtask

  task automatic test_backpressure;
    int n;
    apply_reset;
    n = 0;
    for (int i = 0; i < 40 && bus.tuple_in_ready; i++) begin
      drive(1'b1, 16'd100, tup_of(i));
      n++;
      step;
    end
    total++; if (n !== 28) begin bad++; $display("FAIL bp_writes: got=%0d exp=28", n); end
    drive(1'b1, 16'd100, tup_of(77));
    step;
    step;
    step;
    total++; if (bus.tuple_in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low: got=%b exp=0", bus.tuple_in_ready); end
    total++; if (stored_cnt !== 32'd28 || overflow !== 1'b0) begin
      bad++; $display("FAIL bp_hold: got stored=%0d ovf=%b exp 28/0", stored_cnt, overflow);
    end
    total++; if (bus.fifo_data_out !== mk_word(23'd0, 16'd100, tup_of(0))) begin
      bad++; $display("FAIL bp_head: got=%h exp=%h", bus.fifo_data_out, mk_word(23'd0, 16'd100, tup_of(0)));
    end
    drive(1'b0, 16'd0, '0);
    bus.fifo_rd_en = 1'b1;
    step;
    bus.fifo_rd_en = 1'b0;
    total++; if (bus.tuple_in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back: got=%b exp=1", bus.tuple_in_ready); end
    total++; if (bus.fifo_data_out !== mk_word(23'd1, 16'd100, tup_of(1))) begin
      bad++; $display("FAIL bp_head_after_pop: got=%h exp=%h", bus.fifo_data_out, mk_word(23'd1, 16'd100, tup_of(1)));
    end
  endtask

  task automatic test_seq_wrap;
    logic [22:0] exp_seq [3];
    exp_seq = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000};
    apply_reset;
    force dut.seq_q = 23'h7FFFFE;
    #1;
    release dut.seq_q;
    bus.fifo_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'd200, tup_of(40 + i));
      step;
      total++; if (bus.fifo_data_out !== mk_word(exp_seq[i], 16'd200, tup_of(40 + i))) begin
        bad++; $display("FAIL wrap_word%0d: got=%h exp=%h", i, bus.fifo_data_out, mk_word(exp_seq[i], 16'd200, tup_of(40 + i)));
      end
    end
    drive(1'b0, 16'd0, '0);
    bus.fifo_rd_en = 1'b0;
  endtask

  task automatic test_push_pop;
    apply_reset;
    drive(1'b1, 16'd300, tup_of(0));
    step;
    bus.fifo_rd_en = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      drive(1'b1, 16'd300, tup_of(k));
      step;
      total++; if (bus.fifo_empty !== 1'b0 || bus.fifo_data_out !== mk_word(23'(k), 16'd300, tup_of(k))) begin
        bad++; $display("FAIL pp_cycle%0d: got empty=%b data=%h exp empty=0 data=%h", k, bus.fifo_empty,
                        bus.fifo_data_out, mk_word(23'(k), 16'd300, tup_of(k)));
      end
    end
    drive(1'b0, 16'd0, '0);
    step;
    bus.fifo_rd_en = 1'b0;
    total++; if (bus.fifo_empty !== 1'b1 || stored_cnt !== 32'd51) begin
      bad++; $display("FAIL pp_end: got empty=%b stored=%0d exp 1/51", bus.fifo_empty, stored_cnt);
    end
  endtask

  task automatic test_soft_and_async_reset;
    apply_reset;
    drive(1'b1, 16'd10, tup_of(50));
    step;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'd500, tup_of(i));
      step;
    end
    total++; if (stored_cnt !== 32'd10 || drop_cnt !== 16'd1) begin
      bad++; $display("FAIL sw_pre: got stored=%0d drop=%0d exp 10/1", stored_cnt, drop_cnt);
    end
    drive(1'b1, 16'd500, tup_of(60));
    sw_rst = 1'b1;
    step;
    sw_rst = 1'b0;
    total++; if (bus.fifo_empty !== 1'b1 || bus.fifo_data_out !== 144'd0) begin
      bad++; $display("FAIL sw_fifo: got empty=%b data=%h exp empty=1 data=0", bus.fifo_empty, bus.fifo_data_out);
    end
    total++; if (stored_cnt !== 32'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL sw_counters: got stored=%0d drop=%0d ovf=%b exp 0/0/0", stored_cnt, drop_cnt, overflow);
    end
    step;
    total++; if (bus.fifo_data_out !== mk_word(23'd0, 16'd500, tup_of(60)) || stored_cnt !== 32'd1) begin
      bad++; $display("FAIL sw_restart: got data=%h stored=%0d exp data=%h stored=1", bus.fifo_data_out, stored_cnt,
                      mk_word(23'd0, 16'd500, tup_of(60)));
    end
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 16'd600, tup_of(i));
      step;
    end
    drive(1'b1, 16'd600, tup_of(70));
    #3;
    resetn = 1'b0;
    #1;
    total++; if (bus.fifo_empty !== 1'b1 || bus.fifo_data_out !== 144'd0 || bus.tuple_in_ready !== 1'b0) begin
      bad++; $display("FAIL async_fifo: got empty=%b data=%h ready=%b exp 1/0/0", bus.fifo_empty,
                      bus.fifo_data_out, bus.tuple_in_ready);
    end
    total++; if (stored_cnt !== 32'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL async_counters: got stored=%0d drop=%0d ovf=%b exp 0/0/0", stored_cnt, drop_cnt, overflow);
    end
    #2;
    resetn = 1'b1;
    step;
    drive(1'b0, 16'd0, '0);
    total++; if (bus.fifo_data_out !== mk_word(23'd0, 16'd600, tup_of(70)) || stored_cnt !== 32'd1) begin
      bad++; $display("FAIL async_restart: got data=%h stored=%0d exp data=%h stored=1", bus.fifo_data_out, stored_cnt,
                      mk_word(23'd0, 16'd600, tup_of(70)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_back_to_back;
    test_len_filter;
    test_backpressure;
    test_seq_wrap;
    test_push_pop;
    test_soft_and_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
